alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 103 ++++++++++
 tb/tb_alu_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: 4-state fetch/decode/exec/jump sequencer driving an external 4-bit ALU.
module alu_sequencer #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [11:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic [3:0]  in_port,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [2:0]  alu_f,
  input  logic [3:0]  alu_y,
  input  logic        alu_c,
  input  logic        alu_z,
  output logic [3:0]  acc,
  output logic        flag_c,
  output logic        flag_z,
  output logic [3:0]  out_port,
  output logic        out_valid
);
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, JLOAD} state_t;
  state_t      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [7:0]  ir_q, ir_d;
  logic [3:0]  acc_q, acc_d, out_q, out_d;
  logic        c_q, c_d, z_q, z_d, ov_q, ov_d;
  logic [3:0]  op, imm;
  logic        ex, alu_op, taken;
  assign op        = ir_q[7:4];
  assign imm       = ir_q[3:0];
  assign ex        = state_q == EXEC;
  assign alu_op    = op >= 4'd1 && op <= 4'd5;
  assign taken     = op == 4'd7 || (op == 4'd8 && c_q) || (op == 4'd9 && z_q);
  assign alu_f     = !ex ? 3'b000 : op == 4'd1 ? 3'b001 : (op == 4'd2 || op == 4'd3) ? 3'b010 :
                     op == 4'd4 ? 3'b100 : op == 4'd5 ? 3'b011 : 3'b000;
  assign alu_b     = !ex ? 4'd0 : op == 4'd3 ? in_port : alu_op ? imm : 4'd0;
  assign alu_a     = acc_q;
  assign prog_addr = pc_q;
  assign acc       = acc_q;
  assign flag_c    = c_q;
  assign flag_z    = z_q;
  assign out_port  = out_q;
  assign out_valid = ov_q;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    c_d     = c_q;
    z_d     = z_q;
    out_d   = out_q;
    ov_d    = 1'b0;
    case (state_q)
      FETCH: begin
        pc_d    = run ? pc_q + 12'd1 : pc_q;
        state_d = run ? DECODE : FETCH;
      end
      DECODE: begin
        ir_d = prog_data;
        // jumps consume their second byte here so JLOAD sees it on prog_data
        if (prog_data[7:4] >= 4'd7 && prog_data[7:4] <= 4'd9) begin
          pc_d    = pc_q + 12'd1;
          state_d = JLOAD;
        end else state_d = EXEC;
      end
      EXEC: begin
        acc_d   = (alu_op && op != 4'd1) ? alu_y : acc_q;
        c_d     = alu_op ? alu_c : c_q;
        z_d     = alu_op ? alu_z : z_q;
        out_d   = op == 4'd6 ? acc_q : out_q;
        ov_d    = op == 4'd6;
        state_d = FETCH;
      end
      default: begin
        pc_d    = taken ? {imm, prog_data} : pc_q;
        state_d = FETCH;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      z_q     <= z_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed scenarios plus random programs checked against an instruction-level model.
module tb_alu_sequencer;
  logic        clk = 0, reset = 1, run = 0;
  logic [11:0] prog_addr;
  logic [7:0]  prog_data;
  logic [3:0]  in_port = 0, alu_a, alu_b, alu_y, acc, out_port;
  logic [2:0]  alu_f;
  logic        alu_c, alu_z, flag_c, flag_z, out_valid;
  logic [7:0]  rom [4096];
  int checks = 0, errors = 0;
  int m_pc, m_acc, m_c, m_z, m_out;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .prog_addr(prog_addr), .prog_data(prog_data),
    .in_port(in_port), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y),
    .alu_c(alu_c), .alu_z(alu_z), .acc(acc), .flag_c(flag_c), .flag_z(flag_z),
    .out_port(out_port), .out_valid(out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) prog_data <= rom[prog_addr];

  // external ALU: compare reports borrow in alu_c, add reports carry
  always_comb begin
    alu_c = 1'b0;
    alu_y = 4'd0;
    case (alu_f)
      3'b000: alu_y = alu_a;
      3'b010: alu_y = alu_b;
      3'b001: {alu_c, alu_y} = {1'b0, alu_a} - {1'b0, alu_b};
      3'b011: {alu_c, alu_y} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b100: alu_y = ~(alu_a | alu_b);
      default: alu_y = 4'd0;
    endcase
  end
  assign alu_z = alu_y == 4'd0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    foreach (rom[i]) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1;
    run = 1;
    step();
    reset = 0;
    check("rst_pc", prog_addr, 0);
    check("rst_acc", acc, 0);
    check("rst_c", flag_c, 0);
    check("rst_z", flag_z, 0);
    check("rst_ov", out_valid, 0);
    check("rst_outp", out_port, 0);
    m_pc = 0; m_acc = 0; m_c = 0; m_z = 0; m_out = 0;
  endtask

  task automatic run_n(input int n);
    run = 1;
    repeat (n) step();
  endtask

  task automatic iss(input int inp, output bit was_out);
    int op, imm, r, lo;
    op = rom[m_pc] / 16;
    imm = rom[m_pc] % 16;
    m_pc = (m_pc + 1) % 4096;
    was_out = 0;
    if (op == 1) begin
      m_c = m_acc < imm;
      m_z = m_acc == imm;
    end else if (op >= 2 && op <= 5) begin
      r = op == 2 ? imm : op == 3 ? inp : op == 4 ? 15 - (m_acc | imm) : m_acc + imm;
      m_c = r > 15;
      m_acc = r % 16;
      m_z = m_acc == 0;
    end else if (op == 6) begin
      m_out = m_acc;
      was_out = 1;
    end else if (op >= 7 && op <= 9) begin
      lo = rom[m_pc];
      m_pc = (m_pc + 1) % 4096;
      if (op == 7 || (op == 8 && m_c != 0) || (op == 9 && m_z != 0)) m_pc = imm * 256 + lo;
    end
  endtask

  initial begin
    bit wo;
    int inp;
    clear_rom();
    rom[0] = 8'h27; rom[1] = 8'h55; rom[2] = 8'h60;
    do_reset();
    run_n(6);
    check("d1_acc", acc, 4'hC);
    check("d1_c", flag_c, 0);
    check("d1_z", flag_z, 0);
    run_n(3);
    check("d1_ov", out_valid, 1);
    check("d1_outp", out_port, 4'hC);
    step();
    check("d1_ov_drop", out_valid, 0);
    check("d1_outp_hold", out_port, 4'hC);

    clear_rom();
    rom[0] = 8'h2F; rom[1] = 8'h51; rom[2] = 8'h80; rom[3] = 8'h20;
    do_reset();
    run_n(6);
    check("d2_acc", acc, 0);
    check("d2_c", flag_c, 1);
    check("d2_z", flag_z, 1);
    run_n(3);
    check("d2_pc", prog_addr, 12'h020);

    clear_rom();
    rom[0] = 8'h23; rom[1] = 8'h15; rom[2] = 8'h13;
    do_reset();
    run_n(6);
    check("d3_acc", acc, 3);
    check("d3_c", flag_c, 1);
    check("d3_z", flag_z, 0);
    run_n(3);
    check("d3_acc2", acc, 3);
    check("d3_c2", flag_c, 0);
    check("d3_z2", flag_z, 1);

    clear_rom();
    rom[0] = 8'h7F; rom[1] = 8'hFE; rom[12'hFFE] = 8'h29; rom[12'hFFF] = 8'h00;
    do_reset();
    run_n(3);
    check("d4_pc_jmp", prog_addr, 12'hFFE);
    run_n(3);
    check("d4_acc", acc, 9);
    run_n(3);
    check("d4_wrap", prog_addr, 0);

    clear_rom();
    rom[0] = 8'h27; rom[1] = 8'h19; rom[2] = 8'h70; rom[3] = 8'h40;
    do_reset();
    run_n(8);
    check("d5_pre_c", flag_c, 1);
    reset = 1;
    step();
    reset = 0;
    run = 0;
    check("d5_pc", prog_addr, 0);
    check("d5_acc", acc, 0);
    check("d5_c", flag_c, 0);
    check("d5_ov", out_valid, 0);
    step();
    check("d5_fetch_hold", prog_addr, 0);

    clear_rom();
    rom[0] = 8'h27; rom[1] = 8'h55;
    do_reset();
    run_n(3);
    run = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("d6_hold_pc", prog_addr, 1);
      check("d6_hold_f", alu_f, 0);
      check("d6_hold_acc", acc, 7);
    end
    run_n(3);
    check("d6_resume_acc", acc, 4'hC);
    check("d6_resume_pc", prog_addr, 2);

    foreach (rom[i]) rom[i] = 8'($urandom);
    do_reset();
    for (int n = 0; n < 400; n++) begin
      run = 0;
      repeat ($urandom_range(0, 2)) begin
        in_port = 4'($urandom);
        step();
        check("r_hold_pc", prog_addr, m_pc);
        check("r_hold_ov", out_valid, 0);
        check("r_hold_f", alu_f, 0);
      end
      inp = $urandom_range(0, 15);
      in_port = 4'(inp);
      run = 1;
      step();
      run = 1'($urandom);
      step();
      run = 1'($urandom);
      step();
      iss(inp, wo);
      check("r_pc", prog_addr, m_pc);
      check("r_acc", acc, m_acc);
      check("r_c", flag_c, m_c);
      check("r_z", flag_z, m_z);
      check("r_ov", out_valid, int'(wo));
      if (wo) check("r_outp", out_port, m_out);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
